// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
package inst_mem_pkg;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] idx;
      logic        misal;
      logic        oor;
   } addr_chk_t;

   // Split a byte address into word index plus alignment and range flags.
   function automatic addr_chk_t decode_addr(input logic [31:0] addr,
                                             input int unsigned addr_w,
                                             input int unsigned depth);
      addr_chk_t r;
      logic [31:0] mask;
      mask    = (32'd1 << addr_w) - 32'd1;
      r.idx   = (addr >> 2) & mask;
      r.misal = (addr[1:0] != 2'b00);
      r.oor   = ((addr >> (addr_w + 2)) != 32'd0) || (r.idx >= depth);
      return r;
   endfunction

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one read-first read port.
module inst_mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // No reset on the array or its output register so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/inst_mem_sync.sv
// Writable instruction memory: zero-fill sweep after reset, program port,
// one-cycle fetch with misaligned/out-of-range flagging.
module inst_mem_sync
   import inst_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              init_busy,
   input  logic              prog_en,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_inst,
   output logic              fetch_err
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              vld_q, vld_d;
   logic              err_q, err_d;
   logic              have_q, have_d;

   addr_chk_t         chk;
   logic              accept, bad;
   logic              we, re;
   logic [ADDR_W-1:0] waddr, raddr;
   logic [DATA_W-1:0] wdata, rdata;

   assign chk    = decode_addr(fetch_addr, ADDR_W, DEPTH);
   assign bad    = chk.misal | chk.oor;
   assign raddr  = ADDR_W'(chk.idx);
   assign accept = fetch_req && (state_q == ST_RUN);
   assign re     = accept && !bad;

   // Sweep owns the write port during INIT; out-of-range program writes drop.
   always_comb begin
      we    = 1'b0;
      waddr = prog_addr;
      wdata = prog_data;
      if (state_q == ST_INIT) begin
         we    = 1'b1;
         waddr = cnt_q;
         wdata = '0;
      end else if (prog_en && ({1'b0, prog_addr} < (ADDR_W + 1)'(DEPTH))) begin
         we = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      vld_d   = accept;
      err_d   = err_q;
      have_d  = have_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST_IDX) begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      end
      if (accept) begin
         err_d  = bad;
         have_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         have_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         have_q  <= have_d;
      end
   end

   inst_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (re),
      .raddr (raddr),
      .rdata (rdata)
   );

   // The RAM output register only loads on good fetches, so it already holds
   // the sticky word; errors and the post-reset state mask it to a nop.
   assign init_busy   = (state_q == ST_INIT);
   assign fetch_ready = (state_q == ST_RUN);
   assign fetch_valid = vld_q;
   assign fetch_err   = err_q;
   assign fetch_inst  = (err_q || !have_q) ? DATA_W'(NOP_INST) : rdata;

endmodule
